// File: rtl/axi_pinmux_pkg.sv
// Shared constants, response codes, write-FSM states and mux select codes
// for the AXI4-Lite pin-multiplexer slave.
package axi_pinmux_pkg;

  localparam logic [4:0] OFF_MUX_SEL  = 5'h00;
  localparam logic [4:0] OFF_GPIO_OUT = 5'h04;
  localparam logic [4:0] OFF_GPIO_OE  = 5'h08;
  localparam logic [4:0] OFF_SCRATCH  = 5'h0C;
  localparam logic [4:0] OFF_PIN_IN   = 5'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HAVE_AW = 2'd1,
    HAVE_W  = 2'd2,
    RESP    = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    SEL_GPIO = 2'd0,
    SEL_ALT1 = 2'd1,
    SEL_ALT2 = 2'd2,
    SEL_ALT3 = 2'd3
  } mux_sel_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_pinmux_cell.sv
// One pad's 4:1 output/tristate selector: GPIO or one of three alternate
// functions.
module axi_pinmux_cell
  import axi_pinmux_pkg::*;
(
  input  logic [1:0] sel,
  input  logic       gpio_out,
  input  logic       gpio_oe,
  input  logic [2:0] alt_o,
  input  logic [2:0] alt_t,
  output logic       pin_o,
  output logic       pin_t
);

  always_comb begin
    pin_o = gpio_out;
    pin_t = ~gpio_oe;
    case (mux_sel_e'(sel))
      SEL_GPIO: begin
        pin_o = gpio_out;
        pin_t = ~gpio_oe;
      end
      SEL_ALT1: begin
        pin_o = alt_o[0];
        pin_t = alt_t[0];
      end
      SEL_ALT2: begin
        pin_o = alt_o[1];
        pin_t = alt_t[1];
      end
      SEL_ALT3: begin
        pin_o = alt_o[2];
        pin_t = alt_t[2];
      end
      default: begin
        pin_o = gpio_out;
        pin_t = ~gpio_oe;
      end
    endcase
  end

endmodule

// File: rtl/axi_pinmux_lite_slave.sv
// AXI4-Lite register file for the pin multiplexer (select, GPIO, scratch,
// synchronised pad input) driving one mux cell per pad.
module axi_pinmux_lite_slave
  import axi_pinmux_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_PINS           = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [3*NUM_PINS-1:0]           alt_o,
  input  logic [3*NUM_PINS-1:0]           alt_t,
  input  logic [NUM_PINS-1:0]             pin_i,
  output logic [NUM_PINS-1:0]             pin_o,
  output logic [NUM_PINS-1:0]             pin_t
);

  logic [31:0] mux_sel_r;
  logic [31:0] gpio_out_r;
  logic [31:0] gpio_oe_r;
  logic [31:0] scratch_r;

  logic [NUM_PINS-1:0] pin_sync1;
  logic [NUM_PINS-1:0] pin_sync2;
  logic [31:0]         pin_in_val;

  wr_state_e state, state_nxt;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]                   w_data_q;
  logic [3:0]                    w_strb_q;
  logic [1:0]                    bresp_q;

  logic                          awready, wready, bvalid, do_write;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;

  logic [31:0] rdata_q, rd_data;
  logic [1:0]  rresp_q, rd_resp;
  logic        rvalid_q;
  logic        ar_hs;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign pin_in_val = {{(32-NUM_PINS){1'b0}}, pin_sync2};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pin_sync1 <= '0;
      pin_sync2 <= '0;
    end else begin
      pin_sync1 <= pin_i;
      pin_sync2 <= pin_sync1;
    end
  end

  // Write FSM: readiness of each channel follows which half is already held,
  // and the write commits on the edge where the second half arrives.
  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    do_write  = 1'b0;
    wr_addr   = S_AXI_AWADDR;
    wr_data   = S_AXI_WDATA;
    wr_strb   = S_AXI_WSTRB;
    case (state)
      IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        if (S_AXI_AWVALID && S_AXI_WVALID) begin
          do_write  = 1'b1;
          state_nxt = RESP;
        end else if (S_AXI_AWVALID) begin
          state_nxt = HAVE_AW;
        end else if (S_AXI_WVALID) begin
          state_nxt = HAVE_W;
        end
      end
      HAVE_AW: begin
        wready  = 1'b1;
        wr_addr = aw_addr_q;
        if (S_AXI_WVALID) begin
          do_write  = 1'b1;
          state_nxt = RESP;
        end
      end
      HAVE_W: begin
        awready = 1'b1;
        wr_data = w_data_q;
        wr_strb = w_strb_q;
        if (S_AXI_AWVALID) begin
          do_write  = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        bvalid = 1'b1;
        if (S_AXI_BREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      mux_sel_r  <= '0;
      gpio_out_r <= '0;
      gpio_oe_r  <= '0;
      scratch_r  <= '0;
    end else begin
      state <= state_nxt;
      if (awready && S_AXI_AWVALID) aw_addr_q <= S_AXI_AWADDR;
      if (wready && S_AXI_WVALID) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (do_write) begin
        bresp_q <= RESP_OKAY;
        case ({wr_addr[4:2], 2'b00})
          OFF_MUX_SEL:  mux_sel_r  <= apply_wstrb(mux_sel_r, wr_data, wr_strb);
          OFF_GPIO_OUT: gpio_out_r <= apply_wstrb(gpio_out_r, wr_data, wr_strb);
          OFF_GPIO_OE:  gpio_oe_r  <= apply_wstrb(gpio_oe_r, wr_data, wr_strb);
          OFF_SCRATCH:  scratch_r  <= apply_wstrb(scratch_r, wr_data, wr_strb);
          default:      bresp_q    <= RESP_SLVERR;
        endcase
      end
    end
  end

  assign ar_hs = S_AXI_ARVALID & ~rvalid_q;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case ({S_AXI_ARADDR[4:2], 2'b00})
      OFF_MUX_SEL:  rd_data = mux_sel_r;
      OFF_GPIO_OUT: rd_data = gpio_out_r;
      OFF_GPIO_OE:  rd_data = gpio_oe_r;
      OFF_SCRATCH:  rd_data = scratch_r;
      OFF_PIN_IN:   rd_data = pin_in_val;
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    axi_pinmux_cell u_cell (
      .sel      (mux_sel_r[2*i +: 2]),
      .gpio_out (gpio_out_r[i]),
      .gpio_oe  (gpio_oe_r[i]),
      .alt_o    ({alt_o[2*NUM_PINS+i], alt_o[NUM_PINS+i], alt_o[i]}),
      .alt_t    ({alt_t[2*NUM_PINS+i], alt_t[NUM_PINS+i], alt_t[i]}),
      .pin_o    (pin_o[i]),
      .pin_t    (pin_t[i])
    );
  end

endmodule
